sys_sysid_regbank: RTL and testbench
====================================

// Module: sys_sysid_regbank
// PURPOSE
// - Parametrised Avalon-MM system-ID slave; successor to the fixed single-word sysid peripheral.
// - Adds a RO ID/timestamp pair, a byte-enabled RW scratch register and a sticky error/status word.
// - Adds an optional 64-bit prescaled uptime counter with coherent hi/lo snapshot.
// - Sits on the Qsys/SOPC fabric beside the CPU; software probes it at boot for build identity.
// PARAMETERS
// - SYSTEM_ID     32'h0000_0000 : value returned at word 0
// - TIMESTAMP     32'h5B99_0FB0 : build timestamp returned at word 1
// - ADDR_W        3             : word-address width (>=3; addresses >=7 are reserved)
// - TICK_DIV_RST  16'd0         : reset value of TICK_DIV (0 = increment every cycle)
// PORTS
// - clock          in   1       system clock, all logic rising-edge
// - reset          in   1       synchronous, active-high reset
// - address        in   ADDR_W  word address
// - read           in   1       read strobe, one-cycle pulse per access
// - write          in   1       write strobe
// - writedata      in   32      write data
// - byteenable     in   4       per-byte write enable
// - readdata       out  32      registered read data
// - readdatavalid  out  1       one-cycle pulse qualifying readdata
// BEHAVIOUR
// - Register map (word addr): 0 ID RO; 1 TIMESTAMP RO; 2 SCRATCH RW; 3 STATUS;
//   4 UPTIME_LO RO; 5 UPTIME_HI RO (shadow); 6 TICK_DIV RW [15:0]; >=7 reserved.
// - Reset: readdata=0, readdatavalid=0, SCRATCH=0, STATUS=0, TICK_DIV=TICK_DIV_RST,
//   prescaler=TICK_DIV_RST, uptime=0, hi shadow=0.
// - Reads: fixed latency 1; read in cycle N -> readdatavalid=1 and readdata in N+1; back-to-back
//   reads every cycle supported; readdata holds its last value while readdatavalid=0.
// - Reserved/absent addresses read 32'h0; writes to them are ignored with no error.
// - Writes: take effect at the clock edge of the strobe; SCRATCH and TICK_DIV honour byteenable
//   (TICK_DIV only bytes 0-1; upper bytes read 0).
// - STATUS[0] WR_RO_ERR: set by any write to addr 0,1,4,5; cleared by writing 1 to bit 0 (W1C).
//   A set and a clear in the same cycle: set wins. STATUS[31:1] read 0.
// - Simultaneous read+write: both performed; the read returns the pre-write value.
// - Prescaler: when =0, reload from TICK_DIV and increment uptime (64-bit, wraps to 0 after
//   2^64-1); otherwise decrement. Writing TICK_DIV reloads the prescaler on the same edge.
// - Snapshot: reading UPTIME_LO returns the live low word and copies the live high word
//   (same cycle value) into the hi shadow; UPTIME_HI returns the shadow, never the live value.
// - Reset mid-access: any read in the reset cycle produces no readdatavalid; pending write dropped.
// CONFIGURATION
// - SYSID_UPTIME_EN defined: prescaler, 64-bit uptime, hi shadow and TICK_DIV are present as above.
// - SYSID_UPTIME_EN undefined: addresses 4-6 are reserved (read 0, writes ignored, writes to
//   4/5 do not set WR_RO_ERR); counter logic is not synthesised.
// TESTING
// - Reset, then read addr 0 and 1 -> readdatavalid one cycle later, data SYSTEM_ID, TIMESTAMP.
// - Write 32'hDEADBEEF to SCRATCH with byteenable=4'b0101, prior 0 -> readback 32'h00AD00EF.
// - Write addr 1 -> STATUS reads 1; write 1 to STATUS -> reads 0; write addr 0 in same cycle
//   as W1C to STATUS impossible, so set then clear on consecutive cycles -> 1 then 0.
// - (EN) TICK_DIV=3 from reset: uptime increments once per 4 cycles; after 40 cycles UPTIME_LO
//   equals 10 +/- 1 per prescaler phase checked by the bench model.
// - (EN) Force uptime to 64'h0000_0001_FFFF_FFFF via a bench hierarchical deposit; read LO at the
//   carry edge, then HI -> HI equals the high word captured with LO, never torn.
// - Build without SYSID_UPTIME_EN: read addr 4,5,6 -> 0; write addr 4 -> STATUS stays 0.

Source files
------------

// File: rtl/sys_sysid_regbank.sv
// sys_sysid_regbank -- Avalon-MM system-ID register bank.
// Word map: 0 ID, 1 TIMESTAMP, 2 SCRATCH, 3 STATUS (bit0 W1C write-to-RO error),
// 4 UPTIME_LO, 5 UPTIME_HI (shadow), 6 TICK_DIV, >=7 reserved (read 0).
// Optional feature macro: SYSID_UPTIME_EN enables the prescaled 64-bit uptime
// counter, its high-word shadow and TICK_DIV. Without it, words 4-6 are reserved.
module sys_sysid_regbank #(
   parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP    = 32'h5B99_0FB0,
   parameter int          ADDR_W       = 3,
   parameter logic [15:0] TICK_DIV_RST = 16'd0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic [3:0]        byteenable,
   output logic [31:0]       readdata,
   output logic              readdatavalid
);

   localparam logic [ADDR_W-1:0] A_ID   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_TS   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_SCR  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(3);
`ifdef SYSID_UPTIME_EN
   localparam logic [ADDR_W-1:0] A_ULO  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_UHI  = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] A_TDIV = ADDR_W'(6);
`endif

   logic [31:0] scratch_q, scratch_d;
   logic        err_q, err_d;
   logic [31:0] readdata_q, readdata_d;
   logic        rdv_q, rdv_d;
   logic [31:0] rd_mux;
   logic        wr_ro_hit;
   logic        scr_wr;

   assign scr_wr = write && (address == A_SCR);

   // Byte-lane merge for SCRATCH writes.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_scr
         assign scratch_d[8*gi +: 8] = (scr_wr && byteenable[gi]) ? writedata[8*gi +: 8]
                                                                   : scratch_q[8*gi +: 8];
      end
   endgenerate

`ifdef SYSID_UPTIME_EN
   logic [15:0] tick_div_q, tick_div_d;
   logic [15:0] presc_q, presc_d;
   logic [63:0] uptime_q, uptime_d;
   logic [31:0] hi_shadow_q, hi_shadow_d;
   logic        tdiv_wr;

   assign tdiv_wr = write && (address == A_TDIV);

   // Only the low two byte lanes of TICK_DIV exist.
   generate
      for (gi = 0; gi < 2; gi++) begin : g_tdiv
         assign tick_div_d[8*gi +: 8] = (tdiv_wr && byteenable[gi]) ? writedata[8*gi +: 8]
                                                                     : tick_div_q[8*gi +: 8];
      end
   endgenerate

   // Prescaler/uptime next state; a TICK_DIV write reloads the prescaler with the new divider,
   // and a LO read latches the live high word so a following HI read is never torn.
   always_comb begin
      presc_d     = presc_q;
      uptime_d    = uptime_q;
      hi_shadow_d = hi_shadow_q;
      if (presc_q == 16'd0) begin
         presc_d  = tick_div_q;
         uptime_d = uptime_q + 64'd1;
      end else begin
         presc_d  = presc_q - 16'd1;
      end
      if (tdiv_wr) begin
         presc_d = tick_div_d;
      end
      if (read && (address == A_ULO)) begin
         hi_shadow_d = uptime_q[63:32];
      end
   end
`endif

   // Writes to read-only words flag an error; the uptime words only count when present.
   always_comb begin
      wr_ro_hit = write && ((address == A_ID) || (address == A_TS));
`ifdef SYSID_UPTIME_EN
      if (write && ((address == A_ULO) || (address == A_UHI))) begin
         wr_ro_hit = 1'b1;
      end
`endif
   end

   // Sticky error bit: a set always beats a W1C clear.
   always_comb begin
      err_d = err_q;
      if (wr_ro_hit) begin
         err_d = 1'b1;
      end else if (write && (address == A_STAT) && writedata[0]) begin
         err_d = 1'b0;
      end
   end

   // Read mux over pre-write register values; absent words read zero.
   always_comb begin
      rd_mux = 32'h0;
      case (address)
         A_ID:   rd_mux = SYSTEM_ID;
         A_TS:   rd_mux = TIMESTAMP;
         A_SCR:  rd_mux = scratch_q;
         A_STAT: rd_mux = {31'h0, err_q};
`ifdef SYSID_UPTIME_EN
         A_ULO:  rd_mux = uptime_q[31:0];
         A_UHI:  rd_mux = hi_shadow_q;
         A_TDIV: rd_mux = {16'h0, tick_div_q};
`endif
         default: rd_mux = 32'h0;
      endcase
   end

   // Fixed one-cycle read latency; readdata holds between reads.
   always_comb begin
      rdv_d      = read;
      readdata_d = read ? rd_mux : readdata_q;
   end

   // State registers with synchronous reset; a reset cycle drops any access in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         scratch_q   <= 32'h0;
         err_q       <= 1'b0;
         readdata_q  <= 32'h0;
         rdv_q       <= 1'b0;
`ifdef SYSID_UPTIME_EN
         tick_div_q  <= TICK_DIV_RST;
         presc_q     <= TICK_DIV_RST;
         uptime_q    <= 64'h0;
         hi_shadow_q <= 32'h0;
`endif
      end else begin
         scratch_q   <= scratch_d;
         err_q       <= err_d;
         readdata_q  <= readdata_d;
         rdv_q       <= rdv_d;
`ifdef SYSID_UPTIME_EN
         tick_div_q  <= tick_div_d;
         presc_q     <= presc_d;
         uptime_q    <= uptime_d;
         hi_shadow_q <= hi_shadow_d;
`endif
      end
   end

   assign readdata      = readdata_q;
   assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_sys_sysid_regbank.sv
// Testbench for sys_sysid_regbank: directed + random accesses, scoreboard-checked.
// Works with and without SYSID_UPTIME_EN.
module tb_sys_sysid_regbank;

   localparam logic [31:0] SYS_ID = 32'hCAFE_0123;
   localparam logic [31:0] TS     = 32'h5B99_0FB0;
   localparam logic [15:0] TDR    = 16'd3;
`ifdef SYSID_UPTIME_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  address = 3'd0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = 32'h0;
   logic [3:0]  byteenable = 4'h0;
   logic [31:0] readdata;
   logic        readdatavalid;

   sys_sysid_regbank #(
      .SYSTEM_ID(SYS_ID), .TIMESTAMP(TS), .ADDR_W(3), .TICK_DIV_RST(TDR)
   ) dut (
      .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
      .readdatavalid(readdatavalid)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // Scoreboard
   logic [31:0] exp_q[$];
   string       nm_q[$];

   // Reference model state
   logic [31:0]     m_scr;
   logic            m_err;
   logic [31:0]     m_shadow;
   logic [15:0]     m_tdiv;
   longint unsigned up_ofs;
   int              ecnt;   // clock edges since reset released

   // Uptime value held before edge m: one increment every (TDR+1) edges after reset.
   function automatic logic [63:0] up_before(input int m);
      return up_ofs + 64'((m - 1) / (int'(TDR) + 1));
   endfunction

   function automatic logic [31:0] model_read(input logic [2:0] a, input int m);
      logic [63:0] u;
      u = up_before(m);
      case (a)
         3'd0: return SYS_ID;
         3'd1: return TS;
         3'd2: return m_scr;
         3'd3: return {31'h0, m_err};
         3'd4: return EN ? u[31:0] : 32'h0;
         3'd5: return EN ? m_shadow : 32'h0;
         3'd6: return EN ? {16'h0, m_tdiv} : 32'h0;
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // One bus cycle: issue, record expectation, update model, advance one edge.
   task automatic cyc(input bit rd, input bit wr, input logic [2:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input string nm);
      int m;
      logic [63:0] u;
      read = rd; write = wr; address = a; writedata = wd; byteenable = be;
      m = ecnt + 1;
      if (rd) begin
         exp_q.push_back(model_read(a, m));
         nm_q.push_back(nm);
         if (EN && a == 3'd4) begin
            u = up_before(m);
            m_shadow = u[63:32];
         end
      end
      if (wr) begin
         if (a == 3'd2) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) m_scr[8*b +: 8] = wd[8*b +: 8];
         end
         if (a == 3'd6 && EN) begin
            for (int b = 0; b < 2; b++)
               if (be[b]) m_tdiv[8*b +: 8] = wd[8*b +: 8];
         end
         if (a == 3'd0 || a == 3'd1 || (EN && (a == 3'd4 || a == 3'd5))) m_err = 1'b1;
         else if (a == 3'd3 && wd[0]) m_err = 1'b0;
      end
      @(posedge clock);
      ecnt++;
      #1;
      read = 1'b0; write = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, "idle");
   endtask

   // Reset with an access in flight: read and write must both be dropped.
   task automatic do_reset();
      reset = 1'b1; read = 1'b1; write = 1'b1; address = 3'd2;
      writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
      @(posedge clock);
      #1;
      reset = 1'b0; read = 1'b0; write = 1'b0;
      ecnt = 0; m_scr = 32'h0; m_err = 1'b0; m_shadow = 32'h0; m_tdiv = TDR; up_ofs = 0;
   endtask

   // Monitor
   bit          mon_en = 1'b0;
   bit          rst_seen = 1'b0;
   logic [31:0] last_rd = 32'h0;

   always @(posedge clock) rst_seen <= reset;

   always @(negedge clock) begin
      if (mon_en) begin
         if (rst_seen) begin
            chk("reset_rdv", {31'h0, readdatavalid}, 32'h0);
            chk("reset_readdata", readdata, 32'h0);
            last_rd = 32'h0;
         end else if (readdatavalid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rdv", {31'h0, readdatavalid}, 32'h0);
            end else begin
               chk(nm_q.pop_front(), readdata, exp_q.pop_front());
            end
            last_rd = readdata;
         end else begin
            chk("readdata_hold", readdata, last_rd);
         end
      end
   end

   initial begin
      logic [2:0]  a;
      logic [31:0] wd;
      logic [3:0]  be;
      bit          rd, wr;

      ecnt = 0; m_scr = 0; m_err = 0; m_shadow = 0; m_tdiv = TDR; up_ofs = 0;
      repeat (2) @(posedge clock);
      #1;
      do_reset();
      mon_en = 1'b1;

      // Identity words, back to back, and SCRATCH untouched by the write dropped in reset.
      cyc(1, 0, 3'd0, 32'h0, 4'h0, "rd_id");
      cyc(1, 0, 3'd1, 32'h0, 4'h0, "rd_timestamp");
      cyc(1, 0, 3'd2, 32'h0, 4'h0, "rd_scratch_after_reset");

      // Byte-enabled SCRATCH write.
      cyc(0, 1, 3'd2, 32'hDEAD_BEEF, 4'b0101, "wr_scratch");
      cyc(1, 0, 3'd2, 32'h0, 4'h0, "rd_scratch_be0101");
      // Simultaneous read+write returns the pre-write value.
      cyc(1, 1, 3'd2, 32'h1234_5678, 4'hF, "rdwr_scratch_prewrite");
      cyc(1, 0, 3'd2, 32'h0, 4'h0, "rd_scratch_full");

      // STATUS sticky error and W1C.
      cyc(0, 1, 3'd1, 32'h0, 4'hF, "wr_ro_ts");
      cyc(1, 0, 3'd3, 32'h0, 4'h0, "rd_status_set");
      cyc(0, 1, 3'd3, 32'h0000_0001, 4'hF, "w1c_status");
      cyc(1, 0, 3'd3, 32'h0, 4'h0, "rd_status_clr");
      cyc(0, 1, 3'd0, 32'h0, 4'hF, "wr_ro_id");
      cyc(1, 0, 3'd3, 32'h0, 4'h0, "rd_status_set2");
      cyc(0, 1, 3'd3, 32'hFFFF_FFFE, 4'hF, "w0_status");
      cyc(1, 0, 3'd3, 32'h0, 4'h0, "rd_status_w0_keeps");
      cyc(0, 1, 3'd3, 32'h0000_0001, 4'hF, "w1c_status2");
      cyc(1, 0, 3'd3, 32'h0, 4'h0, "rd_status_clr2");

      // Words 4-7: counter words when present, reserved otherwise.
      cyc(1, 0, 3'd4, 32'h0, 4'h0, "rd_addr4");
      cyc(1, 0, 3'd5, 32'h0, 4'h0, "rd_addr5");
      cyc(1, 0, 3'd6, 32'h0, 4'h0, "rd_addr6");
      cyc(1, 0, 3'd7, 32'h0, 4'h0, "rd_addr7");
      cyc(0, 1, 3'd7, 32'hFFFF_FFFF, 4'hF, "wr_addr7");
      cyc(0, 1, 3'd4, 32'hFFFF_FFFF, 4'hF, "wr_addr4");
      cyc(1, 0, 3'd3, 32'h0, 4'h0, "rd_status_after_wr4");
      cyc(0, 1, 3'd3, 32'h0000_0001, 4'hF, "w1c_status3");

      // Uptime after ~40 cycles with TICK_DIV=3.
      idle(40);
      cyc(1, 0, 3'd4, 32'h0, 4'h0, "rd_uptime_lo_40");
      cyc(1, 0, 3'd5, 32'h0, 4'h0, "rd_uptime_hi_40");

      // Random traffic (TICK_DIV left alone so the uptime model stays valid).
      for (int i = 0; i < 300; i++) begin
         a  = 3'($urandom_range(0, 7));
         rd = ($urandom_range(0, 9) < 6);
         wr = ($urandom_range(0, 9) < 4);
         wd = $urandom;
         be = 4'($urandom_range(0, 15));
         if (EN && a == 3'd6) wr = 1'b0;
         cyc(rd, wr, a, wd, be, "rand_rd");
      end

`ifdef SYSID_UPTIME_EN
      // Coherent snapshot across the low-word carry.
      dut.uptime_q = 64'h0000_0001_FFFF_FFFF;
      up_ofs = 64'h0000_0001_FFFF_FFFF - 64'(ecnt / (int'(TDR) + 1));
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, 3'd4, 32'h0, 4'h0, "snap_lo");
         cyc(1, 0, 3'd5, 32'h0, 4'h0, "snap_hi");
      end
      idle(8);
      cyc(1, 0, 3'd5, 32'h0, 4'h0, "snap_hi_stale");

      // TICK_DIV byte enables (uptime no longer checked after this).
      cyc(0, 1, 3'd6, 32'hABCD_1234, 4'hF, "wr_tdiv");
      cyc(1, 0, 3'd6, 32'h0, 4'h0, "rd_tdiv_full");
      cyc(0, 1, 3'd6, 32'h0000_5600, 4'b0010, "wr_tdiv_b1");
      cyc(1, 0, 3'd6, 32'h0, 4'h0, "rd_tdiv_b1");
`endif

      // Drain and confirm every expected response arrived.
      idle(4);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
